cic_integrator_chain: RTL and testbench
=======================================

// Module: cic_integrator_chain
// PURPOSE
//  N-stage cascaded integrator section of the CIC decimator. Parametrised successor to the single-stage integrator.
//  Sign-extends input samples to the Hogenauer register width and accumulates through N pipelined stages.
//  Generates a decimation strobe every R samples so the downstream comb section can take its samples.
//  Sits between the ADC/NCO mixer output and the comb chain.
// PARAMETERS
//  IW   5  input sample width, two's complement
//  N    3  number of integrator stages (1..8)
//  R    8  decimation ratio (>=2); period of o_dec
//  M    1  differential delay of the downstream comb (1 or 2); used only for width growth
//  OW   IW + N*$clog2(R*M)  localparam, internal accumulator width (defaults give 14)
//  OTW  OW  output width when CIC_INT_TRUNC_EN is defined (OTW <= OW)
// PORTS
//  i_clk     in   1          clock; all logic on the rising edge
//  i_reset   in   1          asynchronous, active-high reset
//  i_ce      in   1          sample enable; one input sample per cycle where i_ce=1
//  i_clr     in   1          synchronous clear of the whole chain
//  i_data    in   IW         signed input sample
//  o_data    out  OW|OTW     signed output of the last stage
//  o_valid   out  1          o_data updated this cycle
//  o_dec     out  1          decimation strobe, qualified by o_valid
// BEHAVIOUR
//  Reset (i_reset=1, async): all accumulators = 0, phase counter = 0, o_data = 0, o_valid = 0, o_dec = 0.
//  Priority: i_reset > i_clr > i_ce.
//  i_clr=1 at the clock edge: same state as after reset, whatever i_ce is. Takes effect on that edge.
//  On each edge with i_ce=1 (and no clear), all of the following update together from old register values:
//   - acc[0] <= acc[0] + sext(i_data) to OW bits.
//   - acc[k] <= acc[k] + acc[k-1], for k = 1..N-1.
//   - o_data <= acc[N-1] (old value).
//   - o_valid <= 1.
//   - o_dec <= (cnt == R-1).
//   - cnt <= (cnt == R-1) ? 0 : cnt + 1.
//  On each edge with i_ce=0: o_valid <= 0 and o_dec <= 0. Accumulators, cnt and o_data hold.
//  Latency: a sample taken on ce number j first affects o_data after ce number j+N. Idle cycles between ce do not count.
//  Arithmetic: plain OW-bit two's-complement addition with modular wrap-around.
//   - No saturation and no overflow flag. Wrap is correct by design, because the comb section unwraps it.
//  o_dec pulses 1 cycle, coincident with o_valid, on every R-th accepted sample: the R-th, 2R-th, and so on.
//  Back-to-back i_ce is supported, one sample per clock. i_ce may be any duty cycle.
//  Reset or clear mid-operation: partial decimation phase is discarded; the next strobe comes R samples after the clear.
// CONFIGURATION
//  CIC_INT_TRUNC_EN defined:
//   - o_data is OTW bits and equals acc[N-1][OW-1 -: OTW] (MSBs kept, LSBs dropped, no rounding).
//   - Accumulators stay OW bits.
//  CIC_INT_TRUNC_EN undefined: o_data is the full OW bits. OTW is ignored.
// TESTING
//  1 Reset: hold i_reset 3 cycles with i_ce=1 and i_data=7 -> o_data=0, o_valid=0, o_dec=0 throughout. Release: first ce gives o_valid=1, o_data=0.
//  2 Impulse, N=3: i_data=1 on ce0, then 0 on continuous ce.
//    o_data per ce = 0,0,0,1,3,6,10,15 (triangular numbers).
//  3 Step, N=1: i_data=1 on continuous ce -> o_data = 0,1,2,3,...
//    Step, N=3, i_data=-1 -> o_data = 0,0,0,-1,-4,-10,-20.
//  4 Wrap: N=1, IW=5, R=8 (OW=8), i_data=15 for 9 ce.
//    o_data after ce 9 = 120; after ce 10 = 135 mod 256 = -121 signed. The bench checks modular equality.
//  5 Strobe: default params, 20 continuous ce -> o_dec=1 only with samples 8 and 16.
//    Gapped ce (1 of 3 cycles) -> o_dec still on samples 8 and 16. o_valid=0 on idle cycles.
//  6 Clear: assert i_clr with i_ce=1 after sample 5.
//    -> All state 0 and o_valid=0 that cycle. Next o_dec on the 8th sample after the clear.
//    Repeat scenario 2 with CIC_INT_TRUNC_EN defined and OTW=8: o_data = acc>>>6.

Source files
------------

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: N-stage cascaded integrator section of a CIC decimator.
// Input samples are sign-extended to the Hogenauer register width OW and
// accumulated through N pipelined integrator stages with modular wrap-around.
// A decimation strobe marks every R-th accepted sample for the comb section.
// Optional build macro CIC_INT_TRUNC_EN: o_data carries only the OTW MSBs of
// the last accumulator (LSBs dropped, no rounding); accumulators stay OW bits.
module cic_integrator_chain #(
  parameter int IW  = 5,
  parameter int N   = 3,
  parameter int R   = 8,
  parameter int M   = 1,
  parameter int OTW = IW + N * $clog2(R * M),
  localparam int OW = IW + N * $clog2(R * M),
`ifdef CIC_INT_TRUNC_EN
  localparam int DW = OTW
`else
  localparam int DW = OW
`endif
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_clr,
  input  logic [IW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_dec
);

  localparam int CW = $clog2(R);
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  // Reject parameter sets the chain cannot implement.
  if (N < 1 || N > 8) begin : g_bad_n
    $error("cic_integrator_chain: N must be in 1..8");
  end
  if (R < 2) begin : g_bad_r
    $error("cic_integrator_chain: R must be at least 2");
  end
  if (M < 1 || M > 2) begin : g_bad_m
    $error("cic_integrator_chain: M must be 1 or 2");
  end
  if (OTW < 1 || OTW > OW) begin : g_bad_otw
    $error("cic_integrator_chain: OTW must be in 1..OW");
  end

  logic [OW-1:0] acc [N];
  logic [CW-1:0] cnt;
  logic [OW-1:0] data_ext;
  logic          cnt_wrap;

  assign data_ext = {{(OW - IW){i_data[IW-1]}}, i_data};
  assign cnt_wrap = (cnt == CNT_LAST);

  // Integrator pipeline: every stage adds its predecessor's old value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the accumulator array is a handful of flops, not a RAM, and a
      // clean restart of the chain depends on it, so every entry is reset.
      for (int k = 0; k < N; k++) acc[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < N; k++) acc[k] <= '0;
    end else if (i_ce) begin
      // NOTE: non-blocking assignments make each stage read the value its
      // predecessor held before this edge, which is what forms the pipeline.
      acc[0] <= acc[0] + data_ext;
      for (int k = 1; k < N; k++) acc[k] <= acc[k] + acc[k-1];
    end
  end

  // Decimation phase counter: wraps after R accepted samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_ce) begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
    end
  end

  // Output register: last stage value, with valid and decimation strobes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_dec   <= 1'b0;
    end else if (i_clr) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_dec   <= 1'b0;
    end else if (i_ce) begin
`ifdef CIC_INT_TRUNC_EN
      o_data  <= acc[N-1][OW-1 -: OTW];
`else
      o_data  <= acc[N-1];
`endif
      o_valid <= 1'b1;
      o_dec   <= cnt_wrap;
    end else begin
      o_valid <= 1'b0;
      o_dec   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Self-checking bench for cic_integrator_chain. Two instances (N=3 and N=1)
// share one stimulus stream. The reference model keeps the accepted-sample
// history and computes each output as an N-fold running sum written in closed
// form with binomial weights, reduced modulo 2^OW. Expectations go into one
// queue per instance at each clock edge; a monitor pops and compares on the
// falling edge.
module tb_cic_integrator_chain;

  localparam int IW  = 5;
  localparam int R   = 8;
  localparam int OW3 = 14;
  localparam int OW1 = 8;
`ifdef CIC_INT_TRUNC_EN
  localparam int OTW3 = 8;
`else
  localparam int OTW3 = OW3;
`endif
  localparam int OTW1 = OW1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ce  = 1'b0;
  logic            clr = 1'b0;
  logic [IW-1:0]   din = '0;
  logic [OTW3-1:0] data3;
  logic [OTW1-1:0] data1;
  logic            valid3, dec3, valid1, dec1;

  cic_integrator_chain #(.IW(IW), .N(3), .R(R), .M(1), .OTW(OTW3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_clr(clr), .i_data(din),
    .o_data(data3), .o_valid(valid3), .o_dec(dec3)
  );

  cic_integrator_chain #(.IW(IW), .N(1), .R(R), .M(1), .OTW(OTW1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_clr(clr), .i_data(din),
    .o_data(data1), .o_valid(valid1), .o_dec(dec1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   valid;
    logic   dec;
    longint data;
  } exp_t;

  exp_t   q3[$];
  exp_t   q1[$];
  longint hist[$];
  int     nsamp = 0;
  longint held3 = 0;
  longint held1 = 0;
  int     total = 0;
  int     bad   = 0;

  function automatic longint binom(int a, int b);
    longint r = 1;
    for (int i = 1; i <= b; i++) r = r * (a - b + i) / i;
    return r;
  endfunction

  // Value of the last integrator after samples hist[0..t]: an nst-fold
  // running sum, reduced to ow bits, then reduced to its otw MSBs.
  function automatic longint model_out(int nst, int ow, int otw, int t);
    longint sum  = 0;
    longint mask = (longint'(1) << ow) - 1;
    if (t < 0) return 0;
    for (int i = 0; i <= t; i++) sum += hist[i] * binom(t - i + nst - 1, nst - 1);
    return (sum & mask) >> (ow - otw);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the expectation for that edge is queued
  // right after the edge.
  task automatic step(input bit r, input bit c, input bit cl, input logic [IW-1:0] d);
    exp_t e3, e1;
    @(negedge clk);
    #1;
    rst = r; ce = c; clr = cl; din = d;
    @(posedge clk);
    if (r || cl) begin
      hist.delete();
      nsamp = 0;
      held3 = 0;
      held1 = 0;
      e3 = '{valid: 1'b0, dec: 1'b0, data: 0};
      e1 = e3;
    end else if (c) begin
      nsamp++;
      held3 = model_out(3, OW3, OTW3, nsamp - 3 - 1);
      held1 = model_out(1, OW1, OTW1, nsamp - 1 - 1);
      hist.push_back(longint'($signed(d)));
      e3 = '{valid: 1'b1, dec: (nsamp % R == 0), data: held3};
      e1 = '{valid: 1'b1, dec: (nsamp % R == 0), data: held1};
    end else begin
      e3 = '{valid: 1'b0, dec: 1'b0, data: held3};
      e1 = '{valid: 1'b0, dec: 1'b0, data: held1};
    end
    q3.push_back(e3);
    q1.push_back(e1);
  endtask

  // Monitor: compare DUT outputs against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      check("n3_valid", longint'(valid3), longint'(e.valid));
      check("n3_dec",   longint'(dec3),   longint'(e.dec));
      check("n3_data",  longint'(data3),  e.data);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("n1_valid", longint'(valid1), longint'(e.valid));
      check("n1_dec",   longint'(dec1),   longint'(e.dec));
      check("n1_data",  longint'(data1),  e.data);
    end
  end

  initial begin
    // Reset held with ce active and nonzero data.
    repeat (3) step(1'b1, 1'b1, 1'b0, 5'd7);
    // Impulse.
    step(1'b0, 1'b1, 1'b0, 5'd1);
    repeat (10) step(1'b0, 1'b1, 1'b0, 5'd0);
    // Step of +1, then step of -1.
    step(1'b0, 1'b1, 1'b1, 5'd0);
    repeat (9) step(1'b0, 1'b1, 1'b0, 5'd1);
    step(1'b0, 1'b1, 1'b1, 5'd0);
    repeat (9) step(1'b0, 1'b1, 1'b0, 5'h1F);
    // Wrap-around of the 8-bit single-stage accumulator.
    step(1'b0, 1'b1, 1'b1, 5'd0);
    repeat (12) step(1'b0, 1'b1, 1'b0, 5'd15);
    // Strobe with continuous ce.
    step(1'b0, 1'b0, 1'b1, 5'd0);
    repeat (20) step(1'b0, 1'b1, 1'b0, IW'($urandom));
    // Strobe with ce on one cycle of three.
    step(1'b0, 1'b0, 1'b1, 5'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, IW'($urandom));
      repeat (2) step(1'b0, 1'b0, 1'b0, IW'($urandom));
    end
    // Clear with ce active after sample 5.
    step(1'b0, 1'b0, 1'b1, 5'd0);
    repeat (5) step(1'b0, 1'b1, 1'b0, IW'($urandom));
    step(1'b0, 1'b1, 1'b1, 5'd9);
    repeat (18) step(1'b0, 1'b1, 1'b0, IW'($urandom));
    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0, IW'($urandom));
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    check("drain_n3", longint'(q3.size()), 0);
    check("drain_n1", longint'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
